bt656_decoder_p: RTL

- Parametrised successor to the fixed 8-bit camera-path BT.656 decoder.
- Sits between TV_DATA / TD_CLK_27 and the image write FIFO.
- Supports 8- or 10-bit ITU-R BT.656 streams with full EAV/SAV timing-reference parsing, protection-bit checking, and field/line/pixel tracking.
- Emits one 4:2:2 {Y, C} word per luma sample, with a valid strobe that feeds the FIFO wrreq directly.

---
 rtl/bt656_decoder_p.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/bt656_decoder_p.sv
`default_nettype none
// ============================================================================
// Module   : bt656_decoder_p
// Brief    : Parametrised 8/10-bit BT.656 decoder producing 4:2:2 {Y, C} words.
//            Optional macro BT656_ECC_EN enables single-bit XY correction.
// Revision : 1.0 - initial release
// ============================================================================
module bt656_decoder_p #(
    parameter int DATA_W       = 8,
    parameter int PIX_PER_LINE = 720,
    parameter int PIX_CNT_W    = 10,
    parameter int LINE_CNT_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data,
    output logic [2*DATA_W-1:0]     YCbCr,
    output logic                    Data_Valid,
    output logic                    active_video,
    output logic                    field,
    output logic                    vblank,
    output logic [PIX_CNT_W-1:0]    pix_cnt,
    output logic [LINE_CNT_W-1:0]   line_cnt,
    output logic                    sav_pulse,
    output logic                    eav_pulse,
    output logic                    frame_start,
    output logic                    xy_err,
    output logic                    sync_lost,
    output logic                    line_ovf
`ifdef BT656_ECC_EN
    ,
    output logic                    xy_corr
`endif
);

    localparam logic [PIX_CNT_W-1:0] c_PIX_MAX = PIX_CNT_W'(PIX_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_SEARCH = 3'd0,
        S_PRE1   = 3'd1,
        S_PRE2   = 3'd2,
        S_PRE3   = 3'd3,
        S_BLANK  = 3'd4,
        S_ACT_C  = 3'd5,
        S_ACT_Y  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_c;
    logic                r_full;
    logic                w_ones;
    logic                w_zero;
    logic [7:0]          w_xy;
    logic                w_xy_ok;
    logic [2:0]          w_fvh;
    logic                w_sav;
    logic                w_eav;
    logic                w_xy_err;
    logic                w_sync_lost;
    logic                w_latch_c;
    logic                w_emit;
`ifdef BT656_ECC_EN
    logic                w_corr;
`endif

    function automatic logic [6:0] enc(input logic [2:0] fvh);
        logic f, v, h;
        {f, v, h} = fvh;
        return {fvh, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    assign w_ones = &data;
    assign w_zero = ~|data;
    assign w_xy   = data[DATA_W-1 -: 8];

`ifdef BT656_ECC_EN
    // Codewords are at distance >= 4, so at most one candidate lies within 1 bit.
    always_comb begin
        w_xy_ok = 1'b0;
        w_fvh   = w_xy[6:4];
        w_corr  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w_xy[7] && ($countones(enc(3'(i)) ^ w_xy[6:0]) <= 1)) begin
                w_xy_ok = 1'b1;
                w_fvh   = 3'(i);
                w_corr  = (enc(3'(i)) != w_xy[6:0]);
            end
        end
    end
`else
    always_comb begin
        w_fvh   = w_xy[6:4];
        w_xy_ok = w_xy[7] && (enc(w_xy[6:4]) == w_xy[6:0]);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_SEARCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_sav       = 1'b0;
        w_eav       = 1'b0;
        w_xy_err    = 1'b0;
        w_sync_lost = 1'b0;
        w_latch_c   = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_SEARCH, S_BLANK: begin
                if (w_ones) w_next = S_PRE1;
            end
            S_ACT_C: begin
                if (w_ones) w_next = S_PRE1;
                else begin
                    w_latch_c = 1'b1;
                    w_next    = S_ACT_Y;
                end
            end
            S_ACT_Y: begin
                if (w_ones) w_next = S_PRE1;
                else begin
                    w_emit = 1'b1;
                    w_next = S_ACT_C;
                end
            end
            S_PRE1: begin
                if (w_zero)      w_next = S_PRE2;
                else if (w_ones) w_next = S_PRE1;
                else begin
                    w_next      = S_SEARCH;
                    w_sync_lost = 1'b1;
                end
            end
            S_PRE2: begin
                if (w_zero) w_next = S_PRE3;
                else begin
                    w_next      = S_SEARCH;
                    w_sync_lost = 1'b1;
                end
            end
            S_PRE3: begin
                if (!w_xy_ok) begin
                    w_xy_err = 1'b1;
                    w_next   = S_SEARCH;
                end else if (w_fvh[0]) begin
                    w_eav  = 1'b1;
                    w_next = S_BLANK;
                end else begin
                    w_sav  = 1'b1;
                    w_next = w_fvh[1] ? S_BLANK : S_ACT_C;
                end
            end
            default: w_next = S_SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c          <= '0;
            r_full       <= 1'b0;
            YCbCr        <= '0;
            Data_Valid   <= 1'b0;
            active_video <= 1'b0;
            field        <= 1'b0;
            vblank       <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            sav_pulse    <= 1'b0;
            eav_pulse    <= 1'b0;
            frame_start  <= 1'b0;
            xy_err       <= 1'b0;
            sync_lost    <= 1'b0;
            line_ovf     <= 1'b0;
`ifdef BT656_ECC_EN
            xy_corr      <= 1'b0;
`endif
        end else begin
            Data_Valid  <= w_emit;
            sav_pulse   <= w_sav;
            eav_pulse   <= w_eav;
            xy_err      <= w_xy_err;
            sync_lost   <= w_sync_lost;
            frame_start <= w_eav && field && !w_fvh[2];
`ifdef BT656_ECC_EN
            xy_corr     <= w_corr && (w_sav || w_eav);
`endif
            if (w_latch_c) r_c <= data;
            if (w_emit) begin
                YCbCr <= {data, r_c};
                if (r_full) line_ovf <= 1'b1;
            end
            // r_full marks that the last legal pixel index has already been emitted.
            if (Data_Valid) begin
                if (pix_cnt == c_PIX_MAX) r_full  <= 1'b1;
                else                      pix_cnt <= pix_cnt + PIX_CNT_W'(1);
            end
            if (w_eav) begin
                active_video <= 1'b0;
                vblank       <= w_fvh[1];
                field        <= w_fvh[2];
                line_cnt     <= (w_fvh[2] != field) ? '0 : line_cnt + LINE_CNT_W'(1);
            end
            if (w_sav) begin
                pix_cnt  <= '0;
                line_ovf <= 1'b0;
                r_full   <= 1'b0;
                if (!w_fvh[1]) active_video <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
